// File: rtl/adder_pipe_pkg.sv
// Shared defaults, operation encoding and configuration check for the pipelined adder.
// Optional overflow flag is enabled by defining ADDER_PIPE_OVF_EN.
package adder_pipe_pkg;

    localparam int ADDER_WIDTH_DFLT  = 16;
    localparam int ADDER_STAGES_DFLT = 4;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } adder_op_e;

    // Width must split evenly into 1..WIDTH carry-chain chunks.
    function automatic bit adder_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result handshake bundle for adder_pipe; master = producer/consumer side, slave = the unit.
// out_ovf exists only when ADDER_PIPE_OVF_EN is defined.
interface adder_pipe_if #(
    parameter int WIDTH = adder_pipe_pkg::ADDER_WIDTH_DFLT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;
`ifdef ADDER_PIPE_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
`else
    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum
    );
    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum
    );
`endif
endinterface

// File: rtl/adder_pipe_stage.sv
// One CHUNK-bit slice of the carry chain plus its pipeline register; operands travel along
// so later slices can add their own chunk. ADDER_PIPE_OVF_EN adds an overflow output.
module adder_pipe_stage
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DFLT,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             sub_i,
    input  logic             carry_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             sub_o,
`ifdef ADDER_PIPE_OVF_EN
    output logic             ovf_o,
`endif
    output logic             carry_o
);
    localparam int LO = IDX * CHUNK;

    logic             vld_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
    logic             sub_q, carry_q, carry_d;
    logic             inv;
    logic [CHUNK-1:0] a_c, bx_c, s_c;

    assign inv  = (adder_op_e'(sub_i) == SUB);
    assign a_c  = a_i[LO +: CHUNK];
    assign bx_c = b_i[LO +: CHUNK] ^ {CHUNK{inv}};

    always_comb begin
        sum_d              = sum_i;
        {carry_d, s_c}     = {1'b0, a_c} + {1'b0, bx_c} + {{CHUNK{1'b0}}, carry_i};
        sum_d[LO +: CHUNK] = s_c;
    end

`ifdef ADDER_PIPE_OVF_EN
    logic ovf_q, ovf_d;
    // Carry into the chunk MSB recovered from its sum bit; only the top slice's value is used.
    assign ovf_d = a_c[CHUNK-1] ^ bx_c[CHUNK-1] ^ s_c[CHUNK-1] ^ carry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en_i && vld_i) begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf_o = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (en_i) begin
            vld_q <= vld_i;
            if (vld_i) begin
                a_q     <= a_i;
                b_q     <= b_i;
                sum_q   <= sum_d;
                sub_q   <= sub_i;
                carry_q <= carry_d;
            end
        end
    end

    assign vld_o   = vld_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign sub_o   = sub_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: WIDTH-bit carry chain split over STAGES registered slices, 1 op/cycle.
// Define ADDER_PIPE_OVF_EN to get the signed-overflow output out_ovf.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = ADDER_WIDTH_DFLT,
    parameter int STAGES = ADDER_STAGES_DFLT
) (
    input logic        clk,
    input logic        rst_n,
    adder_pipe_if.slave bus
);
    localparam int CHUNK = (STAGES >= 1) ? (WIDTH / STAGES) : WIDTH;

    generate
        if (!adder_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
            $error("adder_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
        end
    endgenerate

    adder_op_e        op;
    logic             is_sub;
    logic             vld_s   [STAGES+1];
    logic [WIDTH-1:0] a_s     [STAGES+1];
    logic [WIDTH-1:0] b_s     [STAGES+1];
    logic [WIDTH-1:0] sum_s   [STAGES+1];
    logic             sub_s   [STAGES+1];
    logic             carry_s [STAGES+1];
    logic             rdy     [STAGES];
    logic             rdy_chain;

    assign op         = adder_op_e'(bus.in_sub);
    assign is_sub     = (op == SUB);
    assign vld_s[0]   = bus.in_valid;
    assign a_s[0]     = bus.in_a;
    assign b_s[0]     = bus.in_b;
    assign sum_s[0]   = '0;
    assign sub_s[0]   = is_sub;
    assign carry_s[0] = is_sub;

    // A slice may load when it is empty or everything downstream moves this cycle,
    // so bubbles collapse while the output is stalled.
    always_comb begin
        rdy_chain = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy_chain = rdy_chain | !vld_s[k+1];
            rdy[k]    = rdy_chain;
        end
    end

`ifdef ADDER_PIPE_OVF_EN
    logic ovf_s [STAGES];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_pipe_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en_i    (rdy[k]),
            .vld_i   (vld_s[k]),
            .a_i     (a_s[k]),
            .b_i     (b_s[k]),
            .sum_i   (sum_s[k]),
            .sub_i   (sub_s[k]),
            .carry_i (carry_s[k]),
            .vld_o   (vld_s[k+1]),
            .a_o     (a_s[k+1]),
            .b_o     (b_s[k+1]),
            .sum_o   (sum_s[k+1]),
            .sub_o   (sub_s[k+1]),
`ifdef ADDER_PIPE_OVF_EN
            .ovf_o   (ovf_s[k]),
`endif
            .carry_o (carry_s[k+1])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_s[STAGES];
    assign bus.out_sum   = {carry_s[STAGES], sum_s[STAGES]};
`ifdef ADDER_PIPE_OVF_EN
    assign bus.out_ovf   = ovf_s[STAGES-1];
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=16, STAGES=4): directed table, stream, backpressure, reset.
// Overflow checks are compiled in when ADDER_PIPE_OVF_EN is defined.
module tb_adder_pipe;
    import adder_pipe_pkg::*;

    localparam int W = 16;
    localparam int S = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(W)) bus ();

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        adder_op_e    op;
        logic [W:0]   sum;
        logic         ovf;
    } vec_t;

    vec_t       tbl [12];
    logic [W:0] exp_q [$];
`ifdef ADDER_PIPE_OVF_EN
    logic       exp_ovf_q [$];
`endif
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub);
        logic [W-1:0] d;
        if (!sub) return {1'b0, a} + {1'b0, b};
        d = a - b;
        return (a >= b) ? {1'b1, d} : {1'b0, d};
    endfunction

`ifdef ADDER_PIPE_OVF_EN
    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
        logic r;
        r = model_sum(a, b, sub)[W-1];
        if (sub) return (a[W-1] != b[W-1]) && (r != a[W-1]);
        return (a[W-1] == b[W-1]) && (r != a[W-1]);
    endfunction
`endif

    task automatic new_op();
        bus.in_a   = W'($urandom_range(0, 65535));
        bus.in_b   = W'($urandom_range(0, 65535));
        bus.in_sub = 1'($urandom_range(0, 1));
    endtask

    // Score the transfers happening at the coming edge, then advance one cycle.
    task automatic cycle_step(output logic acc);
        logic [W:0] e;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("stream_sum", 32'(bus.out_sum), 32'(e));
`ifdef ADDER_PIPE_OVF_EN
                check("stream_ovf", 32'(bus.out_ovf), 32'(exp_ovf_q.pop_front()));
`endif
            end
        end
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            exp_q.push_back(model_sum(bus.in_a, bus.in_b, bus.in_sub));
`ifdef ADDER_PIPE_OVF_EN
            exp_ovf_q.push_back(model_ovf(bus.in_a, bus.in_b, bus.in_sub));
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(output int n);
        logic acc;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            cycle_step(acc);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_one(input vec_t v, input string tag);
        bus.in_a      = v.a;
        bus.in_b      = v.b;
        bus.in_sub    = v.op;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_sum"}, 32'(bus.out_sum), 32'(v.sum));
`ifdef ADDER_PIPE_OVF_EN
        check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(v.ovf));
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       acc;
        logic       seen;
        logic [W:0] hold_sum;
        int         acc_cnt;
        int         cyc;
        int         n;

        tbl[0]  = '{16'h0005, 16'h0003, ADD, 17'h00008, 1'b0};
        tbl[1]  = '{16'hFFFF, 16'h0001, ADD, 17'h10000, 1'b0};
        tbl[2]  = '{16'h0005, 16'h0003, SUB, 17'h10002, 1'b0};
        tbl[3]  = '{16'h0000, 16'h0001, SUB, 17'h0FFFF, 1'b0};
        tbl[4]  = '{16'h7FFF, 16'h0001, ADD, 17'h08000, 1'b1};
        tbl[5]  = '{16'h8000, 16'h0001, SUB, 17'h17FFF, 1'b1};
        tbl[6]  = '{16'h1234, 16'h4321, ADD, 17'h05555, 1'b0};
        tbl[7]  = '{16'hFFFF, 16'hFFFF, ADD, 17'h1FFFE, 1'b0};
        tbl[8]  = '{16'h0000, 16'h0000, SUB, 17'h10000, 1'b0};
        tbl[9]  = '{16'h0F0F, 16'h00F1, ADD, 17'h01000, 1'b0};
        tbl[10] = '{16'h8000, 16'h8000, ADD, 17'h10000, 1'b1};
        tbl[11] = '{16'h7FFF, 16'hFFFF, SUB, 17'h08000, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum", 32'(bus.out_sum), 32'd0);
`ifdef ADDER_PIPE_OVF_EN
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_one(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back stream with a continuously ready consumer.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        new_op();
        acc_cnt = 0;
        cyc     = 0;
        while (acc_cnt < 100 && cyc < 300) begin
            cycle_step(acc);
            cyc++;
            if (acc) begin
                acc_cnt++;
                new_op();
            end
        end
        check("stream_accept_cycles", 32'(cyc), 32'd100);
        drain(n);
        check("stream_drain_cycles", 32'(n), 32'd4);

        // Consumer stalls while the producer keeps offering.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        new_op();
        acc_cnt  = 0;
        hold_sum = '0;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) begin
                hold_sum = bus.out_sum;
                check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
                check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                check("bp_head", 32'(bus.out_sum), 32'(exp_q[0]));
            end
            if (c == 5) begin
                check("bp_sum_stable", 32'(bus.out_sum), 32'(hold_sum));
                check("bp_in_ready_still_low", 32'(bus.in_ready), 32'd0);
            end
            cycle_step(acc);
            if (acc) begin
                acc_cnt++;
                new_op();
            end
        end
        check("bp_accepted", 32'(acc_cnt), 32'd4);
        drain(n);
        check("bp_drain_cycles", 32'(n), 32'd4);

        // Reset while operations are in flight.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        new_op();
        for (int c = 0; c < 5; c++) begin
            cycle_step(acc);
            if (acc) new_op();
        end
        bus.in_valid = 1'b0;
        check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_out_sum", 32'(bus.out_sum), 32'd0);
        exp_q.delete();
`ifdef ADDER_PIPE_OVF_EN
        exp_ovf_q.delete();
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("rst_no_ghost", 32'(seen), 32'd0);
        run_one(tbl[2], "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
